// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared constants, IR field layout, condition codes and ALU op encoding
package datapath_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_IDX_W  = 4;
    localparam int NUM_REGS   = 16;

    // IR field positions
    localparam int IR_RA_LSB  = 23;   // Ra = IR[26:23]
    localparam int IR_RB_LSB  = 19;   // Rb = IR[22:19]
    localparam int IR_RC_LSB  = 15;   // Rc = IR[18:15]
    localparam int IR_C2_LSB  = 19;   // C2 = IR[20:19]
    localparam int IR_C_W     = 19;   // C  = IR[18:0]

    // Data memory
    localparam int RAM_DEPTH  = 512;
    localparam int RAM_AW     = 9;

    // Branch condition codes held in IR.C2
    typedef enum logic [1:0] {
        C2_EQ_ZERO = 2'b00,
        C2_NE_ZERO = 2'b01,
        C2_GE_ZERO = 2'b10,
        C2_LT_ZERO = 2'b11
    } c2_e;

    // ALU operations; encoded value i+1 corresponds to strobe bit i
    typedef enum logic [3:0] {
        ALU_NONE  = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_MUL   = 4'd3,
        ALU_DIV   = 4'd4,
        ALU_AND   = 4'd5,
        ALU_OR    = 4'd6,
        ALU_SHR   = 4'd7,
        ALU_SHRA  = 4'd8,
        ALU_SHL   = 4'd9,
        ALU_ROR   = 4'd10,
        ALU_ROL   = 4'd11,
        ALU_NEG   = 4'd12,
        ALU_NOT   = 4'd13,
        ALU_INCPC = 4'd14
    } alu_op_e;

    // Strobe vector bit 0 = ADD ... bit 13 = IncPC; lowest set bit wins.
    function automatic alu_op_e alu_op_from_strobes(input logic [13:0] sel);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 13; i >= 0; i--) begin
            if (sel[i]) code = 4'(i + 1);
        end
        return alu_op_e'(code);
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational 64-bit-result ALU (A = Y register, B = bus)
// Ports:
//   a      in  32  first operand (Y register)
//   b      in  32  second operand (bus)
//   op     in  alu_op_e  selected operation
//   result out 64  {high, low}; high half is 0 except for MUL and DIV
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [63:0] result
);

    logic [4:0]  sh;
    logic [63:0] dbl;
    logic [31:0] rot_r;
    logic [31:0] rot_l;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

    assign sh  = b[4:0];
    assign dbl = {a, a};

    // Rotates are taken from a right shift of A concatenated with itself;
    // a left rotate by s is a right rotate by 32-s (s = 0 gives a shift of 32 -> A).
    assign rot_r = 32'(dbl >> sh);
    assign rot_l = 32'(dbl >> (6'd32 - {1'b0, sh}));

    // Low 64 bits of the product of the sign-extended operands equal the signed product.
    assign prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    always_comb begin
        quot = '0;
        rem  = '0;
        if (b == 32'd0) begin
            quot = 32'hFFFF_FFFF;
            rem  = a;
        end else if (b == 32'hFFFF_FFFF) begin
            // Dividing by -1 is handled directly so the most negative dividend wraps cleanly.
            quot = 32'd0 - a;
            rem  = 32'd0;
        end else begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = {32'd0, a + b};
            ALU_SUB:   result = {32'd0, a - b};
            ALU_MUL:   result = prod;
            ALU_DIV:   result = {rem, quot};
            ALU_AND:   result = {32'd0, a & b};
            ALU_OR:    result = {32'd0, a | b};
            ALU_SHR:   result = {32'd0, a >> sh};
            ALU_SHRA:  result = {32'd0, $signed(a) >>> sh};
            ALU_SHL:   result = {32'd0, a << sh};
            ALU_ROR:   result = {32'd0, rot_r};
            ALU_ROL:   result = {32'd0, rot_l};
            ALU_NEG:   result = {32'd0, 32'd0 - b};
            ALU_NOT:   result = {32'd0, ~b};
            ALU_INCPC: result = {32'd0, b + 32'd1};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - single-bus 32-bit CPU datapath with register file, ALU, Z, RAM and I/O ports
// Ports:
//   clock, clear                      clock; synchronous active-low reset
//   *in strobes                       load the named register (Zhighin/Zlowin load from the ALU)
//   *out strobes                      drive the bus (at most one per cycle; none -> bus = 0)
//   MDMuxread                         MDR source: 1 = RAM read data, 0 = bus
//   ADD..IncPC                        ALU operation select (lowest listed wins)
//   Gra, Grb, Grc                     gate IR Ra/Rb/Rc into the register index
//   InPortdata                        external input, sampled every edge
//   RAMread, RAMwrite                 RAM read enable / write strobe (writes MDR at MAR)
//   CONin                             load branch condition from bus against IR.C2
//   OutPortdata, ConFFQ               OutPort register and branch condition flip-flop
module datapath
    import datapath_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Zhighin,
    input  logic        Zlowin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        MARin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        OutPortin,
    input  logic        Rin,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        InPortout,
    input  logic        CSEout,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        MDMuxread,
    input  logic        ADD,
    input  logic        SUB,
    input  logic        MUL,
    input  logic        DIV,
    input  logic        AND,
    input  logic        OR,
    input  logic        SHR,
    input  logic        SHRA,
    input  logic        SHL,
    input  logic        ROR,
    input  logic        ROL,
    input  logic        NEG,
    input  logic        NOT,
    input  logic        IncPC,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic [31:0] InPortdata,
    input  logic        RAMread,
    input  logic        RAMwrite,
    input  logic        CONin,
    output logic [31:0] OutPortdata,
    output logic        ConFFQ
);

    logic [31:0]        r_file [NUM_REGS];
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        pc_q;
    logic [31:0]        ir_q;
    logic [31:0]        mdr_q;
    logic [31:0]        y_q;
    logic [31:0]        in_port_q;
    logic [31:0]        out_port_q;
    logic [RAM_AW-1:0]  mar_q;
    logic [63:0]        z_q;
    logic               con_ff_q;

    logic [31:0]        mem [RAM_DEPTH];
    logic [31:0]        ram_rdata;

    logic [31:0]        bus;
    logic [REG_IDX_W-1:0] reg_idx;
    logic [31:0]        c_sext;
    c2_e                c2;
    logic               cond_met;
    alu_op_e            alu_op;
    logic [63:0]        alu_result;
    logic               unused_ir_bits;

    // Opcode bits are decoded by the control unit, not here.
    assign unused_ir_bits = ^ir_q[31:27];

    assign reg_idx = (ir_q[IR_RA_LSB +: REG_IDX_W] & {REG_IDX_W{Gra}})
                   | (ir_q[IR_RB_LSB +: REG_IDX_W] & {REG_IDX_W{Grb}})
                   | (ir_q[IR_RC_LSB +: REG_IDX_W] & {REG_IDX_W{Grc}});

    assign c_sext = {{(DATA_W - IR_C_W){ir_q[IR_C_W-1]}}, ir_q[IR_C_W-1:0]};
    assign c2     = c2_e'(ir_q[IR_C2_LSB +: 2]);

    // Bus driver select
    always_comb begin
        bus = '0;
        if (HIout)          bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (Zhighout)  bus = z_q[63:32];
        else if (Zlowout)   bus = z_q[31:0];
        else if (PCout)     bus = pc_q;
        else if (MDRout)    bus = mdr_q;
        else if (InPortout) bus = in_port_q;
        else if (CSEout)    bus = c_sext;
        else if (Rout)      bus = r_file[reg_idx];
        else if (BAout)     bus = (reg_idx == '0) ? '0 : r_file[reg_idx];
    end

    assign alu_op = alu_op_from_strobes({IncPC, NOT, NEG, ROL, ROR, SHL, SHRA,
                                         SHR, OR, AND, DIV, MUL, SUB, ADD});

    datapath_alu u_alu (
        .a      (y_q),
        .b      (bus),
        .op     (alu_op),
        .result (alu_result)
    );

    always_comb begin
        cond_met = 1'b0;
        case (c2)
            C2_EQ_ZERO: cond_met = (bus == '0);
            C2_NE_ZERO: cond_met = (bus != '0);
            C2_GE_ZERO: cond_met = ~bus[31];
            C2_LT_ZERO: cond_met = bus[31];
            default:    cond_met = 1'b0;
        endcase
    end

    assign ram_rdata = RAMread ? mem[mar_q] : '0;

    always_ff @(posedge clock) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) r_file[i] <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            pc_q       <= '0;
            ir_q       <= '0;
            mdr_q      <= '0;
            y_q        <= '0;
            in_port_q  <= '0;
            out_port_q <= '0;
            mar_q      <= '0;
            z_q        <= '0;
            con_ff_q   <= 1'b0;
        end else begin
            in_port_q <= InPortdata;
            if (HIin)      hi_q       <= bus;
            if (LOin)      lo_q       <= bus;
            if (PCin)      pc_q       <= bus;
            if (IRin)      ir_q       <= bus;
            if (Yin)       y_q        <= bus;
            if (OutPortin) out_port_q <= bus;
            if (MARin)     mar_q      <= bus[RAM_AW-1:0];
            if (MDRin)     mdr_q      <= MDMuxread ? ram_rdata : bus;
            if (Zlowin)    z_q[31:0]  <= alu_result[31:0];
            if (Zhighin)   z_q[63:32] <= alu_result[63:32];
            if (Rin)       r_file[reg_idx] <= bus;
            if (CONin)     con_ff_q   <= cond_met;
        end
    end

    // RAM is not touched by clear.
    always_ff @(posedge clock) begin
        if (RAMwrite) mem[mar_q] <= mdr_q;
    end

    assign OutPortdata = out_port_q;
    assign ConFFQ      = con_ff_q;

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - self-checking bench for datapath against a behavioural model
module tb_datapath;

    logic clock = 1'b0;
    logic clear;
    logic HIin, LOin, Zhighin, Zlowin, PCin, MDRin, MARin, IRin, Yin, OutPortin, Rin;
    logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, CSEout, Rout, BAout;
    logic MDMuxread;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC;
    logic Gra, Grb, Grc;
    logic [31:0] InPortdata;
    logic RAMread, RAMwrite, CONin;
    logic [31:0] OutPortdata;
    logic ConFFQ;

    int tests  = 0;
    int failed = 0;
    logic [31:0] r_m [16];

    datapath dut (
        .clock(clock), .clear(clear),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin), .PCin(PCin),
        .MDRin(MDRin), .MARin(MARin), .IRin(IRin), .Yin(Yin), .OutPortin(OutPortin), .Rin(Rin),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout),
        .MDRout(MDRout), .InPortout(InPortout), .CSEout(CSEout), .Rout(Rout), .BAout(BAout),
        .MDMuxread(MDMuxread),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR), .SHR(SHR),
        .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .InPortdata(InPortdata), .RAMread(RAMread), .RAMwrite(RAMwrite), .CONin(CONin),
        .OutPortdata(OutPortdata), .ConFFQ(ConFFQ)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_ops(input logic [13:0] o);
        ADD = o[0]; SUB = o[1]; MUL = o[2]; DIV = o[3]; AND = o[4]; OR = o[5]; SHR = o[6];
        SHRA = o[7]; SHL = o[8]; ROR = o[9]; ROL = o[10]; NEG = o[11]; NOT = o[12]; IncPC = o[13];
    endtask

    task automatic idle();
        HIin = 0; LOin = 0; Zhighin = 0; Zlowin = 0; PCin = 0; MDRin = 0; MARin = 0;
        IRin = 0; Yin = 0; OutPortin = 0; Rin = 0;
        HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
        InPortout = 0; CSEout = 0; Rout = 0; BAout = 0; MDMuxread = 0;
        set_ops(14'd0);
        Gra = 0; Grb = 0; Grc = 0; RAMread = 0; RAMwrite = 0; CONin = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller has set the bus source strobes; route the bus to OutPort and compare.
    task automatic show_bus(input string tag, input logic [31:0] exp);
        OutPortin = 1;
        tick();
        check(tag, OutPortdata, exp);
    endtask

    task automatic load_inport(input logic [31:0] v);
        InPortdata = v;
        tick();
    endtask

    task automatic set_ir(input logic [31:0] v);
        load_inport(v);
        InPortout = 1; IRin = 1;
        tick();
    endtask

    task automatic put_reg(input int idx, input logic [31:0] v);
        set_ir(32'(idx) << 23);
        load_inport(v);
        InPortout = 1; Gra = 1; Rin = 1;
        tick();
        r_m[idx] = v;
    endtask

    task automatic get_reg(input int idx, input string tag);
        int f;
        f = $urandom_range(0, 2);
        set_ir(32'(idx) << (f == 0 ? 23 : (f == 1 ? 19 : 15)));
        Gra = (f == 0); Grb = (f == 1); Grc = (f == 2); Rout = 1;
        show_bus(tag, r_m[idx]);
    endtask

    task automatic ram_write(input logic [31:0] addr, input logic [31:0] data);
        load_inport(addr);
        InPortout = 1; MARin = 1;
        tick();
        load_inport(data);
        InPortout = 1; MDRin = 1;
        tick();
        RAMwrite = 1;
        tick();
    endtask

    task automatic fetch();
        PCout = 1; MARin = 1; IncPC = 1; Zlowin = 1;
        tick();
        Zlowout = 1; PCin = 1; RAMread = 1; MDMuxread = 1; MDRin = 1;
        tick();
        MDRout = 1; IRin = 1;
        tick();
    endtask

    task automatic alu_run(input logic [13:0] ops, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi);
        load_inport(a);
        InPortout = 1; Yin = 1;
        tick();
        load_inport(b);
        InPortout = 1; set_ops(ops); Zlowin = 1; Zhighin = 1;
        tick();
        Zlowout = 1; OutPortin = 1;
        tick();
        lo = OutPortdata;
        Zhighout = 1; OutPortin = 1;
        tick();
        hi = OutPortdata;
    endtask

    // Behavioural ALU: op index k in strobe order ADD..IncPC, -1 = nothing selected.
    function automatic logic [63:0] alu_model(input int k, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint rm;
        longint p;
        int s;
        logic [31:0] w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = int'(b[4:0]);
        w  = '0;
        case (k)
            0:  return {32'd0, a + b};
            1:  return {32'd0, a - b};
            2:  begin p = sa * sb; return 64'(p); end
            3:  begin
                    if (b == 0) return {a, 32'hFFFF_FFFF};
                    q  = sa / sb;
                    rm = sa - q * sb;
                    return {rm[31:0], q[31:0]};
                end
            4:  return {32'd0, a & b};
            5:  return {32'd0, a | b};
            6:  return {32'd0, a >> s};
            7:  begin p = sa >>> s; return {32'd0, p[31:0]}; end
            8:  return {32'd0, a << s};
            9:  begin for (int i = 0; i < 32; i++) w[i] = a[(i + s) % 32]; return {32'd0, w}; end
            10: begin for (int i = 0; i < 32; i++) w[i] = a[(i - s + 32) % 32]; return {32'd0, w}; end
            11: return {32'd0, 32'd0 - b};
            12: return {32'd0, ~b};
            13: return {32'd0, b + 32'd1};
            default: return 64'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] lo, hi, a, b, v, c, zold;
        logic [63:0] exp64;
        logic [31:0] addrs [4];
        logic [31:0] datas [4];
        int c2;
        logic cexp;

        idle();
        InPortdata = 32'd0;
        for (int i = 0; i < 16; i++) r_m[i] = '0;

        // Reset
        clear = 0;
        tick();
        clear = 1;
        check("reset_outport", OutPortdata, 32'd0);
        check("reset_conff", {31'd0, ConFFQ}, 32'd0);
        PCout = 1; show_bus("reset_pc", 32'd0);

        // Program: ldi R6,0x7FFFF at 0 and ldi R7,1 at 1
        ram_write(32'd0, 32'h0307_FFFF);
        ram_write(32'd1, 32'h0380_0001);

        // Reset wins over a load strobe in the same cycle; RAM survives reset
        load_inport(32'h0000_1234);
        clear = 0; InPortout = 1; PCin = 1;
        tick();
        clear = 1;
        PCout = 1; show_bus("reset_over_pcin", 32'd0);

        // ldi R6
        fetch();
        Grb = 1; BAout = 1; Yin = 1; tick();
        CSEout = 1; ADD = 1; Zlowin = 1; tick();
        Zlowout = 1; Gra = 1; Rin = 1; tick();
        r_m[6] = 32'hFFFF_FFFF;
        Gra = 1; Rout = 1; show_bus("ldi_r6", 32'hFFFF_FFFF);
        PCout = 1; show_bus("pc_after_fetch1", 32'd1);

        // ldi R7
        fetch();
        Grb = 1; BAout = 1; Yin = 1; tick();
        CSEout = 1; ADD = 1; Zlowin = 1; tick();
        Zlowout = 1; Gra = 1; Rin = 1; tick();
        r_m[7] = 32'd1;
        Gra = 1; Rout = 1; show_bus("ldi_r7", 32'd1);
        PCout = 1; show_bus("pc_after_fetch2", 32'd2);

        // mul R6,R7
        set_ir(32'h0338_0000);
        Gra = 1; Rout = 1; Yin = 1; tick();
        Grb = 1; Rout = 1; MUL = 1; Zlowin = 1; Zhighin = 1; tick();
        Zlowout = 1; LOin = 1; tick();
        Zhighout = 1; HIin = 1; tick();
        HIout = 1; show_bus("mul_hi", 32'hFFFF_FFFF);
        LOout = 1; show_bus("mul_lo", 32'hFFFF_FFFF);

        // mfhi R6 / mflo R7 after scrambling both
        put_reg(6, $urandom & 32'h7FFF_FFFF);
        put_reg(7, $urandom & 32'h7FFF_FFFF);
        set_ir(32'd6 << 23);
        HIout = 1; Gra = 1; Rin = 1; tick();
        set_ir(32'd7 << 23);
        LOout = 1; Gra = 1; Rin = 1; tick();
        r_m[6] = 32'hFFFF_FFFF;
        r_m[7] = 32'hFFFF_FFFF;
        get_reg(6, "mfhi_r6");
        get_reg(7, "mflo_r7");

        // Directed divides
        alu_run(14'd1 << 3, 32'hFFFF_FFF9, 32'd2, lo, hi);
        check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi, 32'hFFFF_FFFF);
        alu_run(14'd1 << 3, 32'd1234, 32'd0, lo, hi);
        check("div_by0_lo", lo, 32'hFFFF_FFFF);
        check("div_by0_hi", hi, 32'd1234);

        // Randomized ALU sweep
        for (int k = 0; k < 14; k++) begin
            for (int j = 0; j < 4; j++) begin
                a = $urandom;
                b = $urandom;
                if (k == 3 && j == 0) b = 32'd0;
                if (k == 3 && j == 1) b = 32'hFFFF_FFFF;
                if (k == 2 && j == 2) begin a = a & 32'hFFFF; b = b & 32'hFFFF; end
                alu_run(14'd1 << k, a, b, lo, hi);
                exp64 = alu_model(k, a, b);
                check($sformatf("alu%0d_lo", k), lo, exp64[31:0]);
                check($sformatf("alu%0d_hi", k), hi, exp64[63:32]);
            end
        end

        // No op selected, and priority between simultaneous ops
        a = $urandom; b = $urandom;
        alu_run(14'd0, a, b, lo, hi);
        check("alu_none_lo", lo, 32'd0);
        check("alu_none_hi", hi, 32'd0);
        alu_run(14'b00_0000_0000_0011, a, b, lo, hi);
        exp64 = alu_model(0, a, b);
        check("alu_prio_add_sub", lo, exp64[31:0]);
        alu_run(14'b01_0000_0000_0100, a, b, lo, hi);
        exp64 = alu_model(2, a, b);
        check("alu_prio_mul_not_lo", lo, exp64[31:0]);
        check("alu_prio_mul_not_hi", hi, exp64[63:32]);

        // Zlow driven and reloaded in one cycle: bus and OutPort see the old value
        alu_run(14'd1, 32'd100, 32'd23, lo, hi);
        zold = 32'd123;
        Zlowout = 1; IncPC = 1; Zlowin = 1; OutPortin = 1;
        tick();
        check("same_cycle_old", OutPortdata, zold);
        Zlowout = 1; show_bus("same_cycle_new", zold + 32'd1);

        // Constant sign extension
        for (int j = 0; j < 4; j++) begin
            c = $urandom & 32'h7FFFF;
            if (j == 0) c = 32'h3FFFF;
            if (j == 1) c = 32'h40000;
            set_ir(($urandom & 32'hFFF8_0000) | c);
            CSEout = 1;
            show_bus("cse", 32'(int'(c) - (c >= 32'h40000 ? 524288 : 0)));
        end

        // R0 through BAout reads zero, through Rout reads its contents
        put_reg(0, $urandom | 32'h1);
        set_ir(32'd0);
        Gra = 1; BAout = 1; show_bus("baout_r0", 32'd0);
        Gra = 1; Rout = 1; show_bus("rout_r0", r_m[0]);
        put_reg(9, $urandom);
        set_ir(32'd9 << 23);
        Gra = 1; BAout = 1; show_bus("baout_r9", r_m[9]);

        // Register file round trip
        for (int j = 0; j < 10; j++) put_reg($urandom_range(0, 15), $urandom);
        for (int i = 0; i < 16; i++) get_reg(i, $sformatf("reg_r%0d", i));

        // RAM: disabled read gives 0, then round trips including the top address
        MDMuxread = 1; MDRin = 1; tick();
        MDRout = 1; show_bus("ram_read_off", 32'd0);
        addrs[0] = 32'd5; addrs[1] = 32'd100; addrs[2] = 32'd300; addrs[3] = 32'd511;
        for (int i = 0; i < 4; i++) begin
            datas[i] = $urandom;
            ram_write(addrs[i], datas[i]);
        end
        for (int i = 0; i < 4; i++) begin
            load_inport(addrs[i]);
            InPortout = 1; MARin = 1; tick();
            RAMread = 1; MDMuxread = 1; MDRin = 1; tick();
            MDRout = 1; show_bus($sformatf("ram_rd_%0d", addrs[i]), datas[i]);
        end

        // Branch condition
        set_ir(32'h0008_0000);
        load_inport(32'd5);
        InPortout = 1; CONin = 1; tick();
        check("conff_ne_5", {31'd0, ConFFQ}, 32'd1);
        set_ir(32'h0000_0000);
        load_inport(32'd5);
        InPortout = 1; CONin = 1; tick();
        check("conff_eq_5", {31'd0, ConFFQ}, 32'd0);
        for (int j = 0; j < 12; j++) begin
            c2 = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: v = 32'd0;
                1: v = 32'd5;
                2: v = 32'h8000_0000;
                default: v = $urandom;
            endcase
            case (c2)
                0: cexp = (v == 0);
                1: cexp = (v != 0);
                2: cexp = ($signed(v) >= 0);
                default: cexp = ($signed(v) < 0);
            endcase
            set_ir(32'(c2) << 19);
            load_inport(v);
            InPortout = 1; CONin = 1; tick();
            check($sformatf("conff_c2_%0d", c2), {31'd0, ConFFQ}, {31'd0, cexp});
        end

        // Final reset clears outputs that are known to be nonzero
        set_ir(32'h0008_0000);
        load_inport(32'd7);
        InPortout = 1; CONin = 1; OutPortin = 1; tick();
        check("pre_reset_out", OutPortdata, 32'd7);
        check("pre_reset_conff", {31'd0, ConFFQ}, 32'd1);
        clear = 0;
        tick();
        clear = 1;
        check("final_reset_out", OutPortdata, 32'd0);
        check("final_reset_conff", {31'd0, ConFFQ}, 32'd0);
        PCout = 1; show_bus("final_reset_pc", 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 clear  in  1  synchronous active-low reset.
REQ-003 HIin, LOin, Zhighin, Zlowin, PCin, MDRin, MARin, IRin, Yin, OutPortin, Rin  in  1 each  register load strobes from bus; Zhighin/Zlowin load from ALU.
REQ-004 HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, CSEout, Rout, BAout  in  1 each  bus-drive strobes, at most one high per cycle.
REQ-005 MDMuxread  in  1  MDR input select: 1 = RAM data, 0 = bus.
REQ-006 ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC  in  1 each  one-hot ALU op select.
REQ-007 Gra, Grb, Grc  in  1 each  select IR field Ra/Rb/Rc as register index.
REQ-008 InPortdata  in  32  external input port value.
REQ-009 RAMread, RAMwrite  in  1 each  memory read enable / write strobe.
REQ-010 CONin  in  1  load branch-condition flip-flop.
REQ-011 OutPortdata  out  32  OutPort register value.
REQ-012 ConFFQ  out  1  branch-condition flip-flop value.

Function
REQ-013 Single 32-bit bus; driver chosen by active out-strobe; no strobe -> bus = 0.
REQ-014 Registers: R0-R15, HI, LO, PC, IR, MDR, Y, InPort, OutPort (32 bit); MAR (9 bit, bus[8:0]); Z (64 bit, Zhigh/Zlow).
REQ-015 IR fields: Ra=[26:23], Rb=[22:19], Rc=[18:15], C2=[20:19], C=[18:0]; index = OR of Gra/Grb/Grc-gated fields.
REQ-016 Rin writes bus into selected register; Rout drives selected register; BAout same except R0 reads 0.
REQ-017 CSEout drives C sign-extended from bit 18 (0x7FFFF -> 0xFFFFFFFF).
REQ-018 ALU A = Y, B = bus, combinational 64-bit result; Zlowin loads result[31:0], Zhighin loads result[63:32], in the same edge.
REQ-019 ADD/SUB/AND/OR/NOT/NEG: 32-bit, upper half 0; NOT/NEG operate on B; wrap-around, no flags.
REQ-020 MUL: signed 32x32 -> 64. DIV: signed A/B, low = quotient, high = remainder (sign of A); B = 0 -> low 0xFFFFFFFF, high = A.
REQ-021 SHR/SHRA/SHL/ROR/ROL: A by B[4:0]; upper half 0.
REQ-022 IncPC: result = B + 1; no op asserted -> result 0; multiple ops: priority in REQ-006 order.
REQ-023 RAM 512x32, async read at MAR when RAMread; else read data 0; RAMwrite stores MDR at mem[MAR] on edge.
REQ-024 MDRin loads RAM data (MDMuxread=1) or bus (0).
REQ-025 InPort samples InPortdata every edge; OutPortin loads OutPort.
REQ-026 CONin loads ConFF from bus vs C2: 00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
REQ-027 Simultaneous load and drive of one register: bus sees old value; new value after edge.

Reset
REQ-028 clear=0 at edge: all registers, Z, ConFF -> 0; OutPortdata=0, ConFFQ=0; RAM retained.
REQ-029 Reset overrides all strobes in that cycle; reset mid-instruction abandons it.

Configuration
REQ-030 RAM_INIT_EN defined: RAM preloaded at time 0 from hex file "ram_init.hex"; undefined: RAM contents 0.

Structure
REQ-031 Package datapath_pkg: IR field positions, RAM depth/address width, C2 codes, ALU op enum.
REQ-032 Sub-module datapath_alu holds REQ-018..REQ-022 combinational logic.

Verification
REQ-033 Reset: clear=0 one edge -> PC=0, ConFFQ=0, OutPortdata=0.
REQ-034 ldi R6: mem[0]=IR Ra=6, Rb=0, C=0x7FFFF; fetch T0-T2, Grb+BAout+Yin, CSEout+ADD+Zlowin, Zlowout+Gra+Rin -> R6=0xFFFFFFFF, PC=1.
REQ-035 ldi R7 C=1 then mul R6,R7 (Y=R6, Grb+Rout+MUL, Zlowout->LO, Zhighout->HI) -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
REQ-036 mfhi R6 / mflo R7 (HIout or LOout, Gra, Rin) -> R6=0xFFFFFFFF, R7=0xFFFFFFFF.
REQ-037 DIV Y=-7, bus=2 -> Zlow=0xFFFFFFFD, Zhigh=0xFFFFFFFF; DIV by 0 -> Zlow=0xFFFFFFFF.
REQ-038 CONin C2=01 bus=5 -> ConFFQ=1; C2=00 bus=5 -> ConFFQ=0.
